// File: rtl/range_cam_multi.sv
// Multi-port range CAM: NUMSRPT independent 3-stage search pipelines
// sharing one entry array with two write ports and a bulk clear.
module range_cam_multi #(
  parameter int NUMADDR = 64,
  parameter int BITADDR = 6,
  parameter int BITRANG = 8,
  parameter int NUMSRPT = 2,
  parameter int RNGMODE = 0,
  parameter int WIDTH   = 2*BITRANG+1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_0,
  input  logic [BITADDR-1:0]         wr_adr_0,
  input  logic [WIDTH-1:0]           wr_din_0,
  input  logic                       write_1,
  input  logic [BITADDR-1:0]         wr_adr_1,
  input  logic [WIDTH-1:0]           wr_din_1,
  input  logic                       clear,
  input  logic [NUMSRPT-1:0]         search,
  input  logic [NUMSRPT*BITRANG-1:0] sr_rng,
  output logic [NUMSRPT-1:0]         sr_vld,
  output logic [NUMSRPT*NUMADDR-1:0] sr_bmp,
  output logic [NUMSRPT-1:0]         sr_hit,
  output logic [NUMSRPT*BITADDR-1:0] sr_adr
);

  logic [NUMADDR-1:0] r_ent_vld;
  logic [BITRANG-1:0] r_min [NUMADDR];
  logic [BITRANG-1:0] r_max [NUMADDR];

  logic [NUMSRPT-1:0] r_s1_vld;
  logic [NUMSRPT-1:0] r_s2_vld;
  logic [NUMSRPT-1:0] r_s3_vld;
  logic [BITRANG-1:0] r_s1_key [NUMSRPT];
  logic [NUMADDR-1:0] r_s2_bmp [NUMSRPT];
  logic [NUMADDR-1:0] r_s3_bmp [NUMSRPT];
  logic [NUMSRPT-1:0] r_s3_hit;
  logic [BITADDR-1:0] r_s3_adr [NUMSRPT];

  logic [NUMADDR-1:0] w_bmp [NUMSRPT];
  logic [NUMSRPT-1:0] w_hit;
  logic [BITADDR-1:0] w_adr [NUMSRPT];

  // Clear first, then port 0, then port 1: later assignments win.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent_vld <= '0;
    end else begin
      if (clear)
        r_ent_vld <= '0;
      if (write_0)
        r_ent_vld[wr_adr_0] <= wr_din_0[2*BITRANG];
      if (write_1)
        r_ent_vld[wr_adr_1] <= wr_din_1[2*BITRANG];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && write_0) begin
      r_min[wr_adr_0] <= wr_din_0[2*BITRANG-1:BITRANG];
      r_max[wr_adr_0] <= wr_din_0[BITRANG-1:0];
    end
    if (!rst && write_1) begin
      r_min[wr_adr_1] <= wr_din_1[2*BITRANG-1:BITRANG];
      r_max[wr_adr_1] <= wr_din_1[BITRANG-1:0];
    end
  end

  always_comb begin
    for (int p = 0; p < NUMSRPT; p++) begin
      w_bmp[p] = '0;
      for (int i = 0; i < NUMADDR; i++) begin
        w_bmp[p][i] = r_ent_vld[i] &&
                      (r_min[i] <= r_s1_key[p]) &&
                      ((RNGMODE != 0) ?
                        (r_s1_key[p] <  r_max[i]) :
                        (r_s1_key[p] <= r_max[i]));
      end
    end
  end

  // Walk downwards so the lowest set index is the last one written.
  always_comb begin
    for (int p = 0; p < NUMSRPT; p++) begin
      w_hit[p] = |r_s2_bmp[p];
      w_adr[p] = '0;
      for (int i = NUMADDR-1; i >= 0; i--) begin
        if (r_s2_bmp[p][i])
          w_adr[p] = BITADDR'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUMSRPT; p++) begin
      r_s1_key[p] <= sr_rng[p*BITRANG +: BITRANG];
      r_s2_bmp[p] <= w_bmp[p];
    end
    if (rst) begin
      r_s1_vld <= '0;
      r_s2_vld <= '0;
    end else begin
      r_s1_vld <= search;
      r_s2_vld <= r_s1_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_vld <= '0;
      r_s3_hit <= '0;
      for (int p = 0; p < NUMSRPT; p++) begin
        r_s3_bmp[p] <= '0;
        r_s3_adr[p] <= '0;
      end
    end else begin
      r_s3_vld <= r_s2_vld;
      for (int p = 0; p < NUMSRPT; p++) begin
        if (r_s2_vld[p]) begin
          r_s3_bmp[p] <= r_s2_bmp[p];
          r_s3_hit[p] <= w_hit[p];
          r_s3_adr[p] <= w_adr[p];
        end
      end
    end
  end

  assign sr_vld = r_s3_vld;
  assign sr_hit = r_s3_hit;

  for (genvar p = 0; p < NUMSRPT; p++) begin : g_out
    assign sr_bmp[p*NUMADDR +: NUMADDR] = r_s3_bmp[p];
    assign sr_adr[p*BITADDR +: BITADDR] = r_s3_adr[p];
  end

endmodule

// File: doc/range_cam_multi.md
Name: range_cam_multi

Overview:
- Parametrised range CAM, successor to the single-port range CAM in the scheduler's rank/range lookup path.
- Each entry holds {valid, min, max}. Every search compares one key against all entries and returns a per-entry match bitmap.
- New versus the previous generation: NUMSRPT independent search ports, a synchronous reset that clears every entry's valid bit, a single-cycle bulk clear, and a selectable inclusive or half-open upper bound.
- Each search port also returns a lowest-index priority-encoded result (hit flag and address) and a result-valid strobe.

Parameters:
- NUMADDR, 64: number of entries.
- BITADDR, 6: address width; NUMADDR <= 2**BITADDR.
- BITRANG, 8: width of min, max and search key (unsigned).
- NUMSRPT, 2: number of search ports.
- RNGMODE, 0: 0 = match when min<=key<=max; 1 = match when min<=key<max.
- WIDTH, 2*BITRANG+1: entry width. Bit [2*BITRANG] = valid, [2*BITRANG-1:BITRANG] = min, [BITRANG-1:0] = max.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- write_0  in  1  write port 0 enable
- wr_adr_0  in  BITADDR  write port 0 address
- wr_din_0  in  WIDTH  write port 0 data
- write_1  in  1  write port 1 enable
- wr_adr_1  in  BITADDR  write port 1 address
- wr_din_1  in  WIDTH  write port 1 data
- clear  in  1  invalidate all entries
- search  in  NUMSRPT  per-port search request
- sr_rng  in  NUMSRPT*BITRANG  per-port key; port p uses bits [p*BITRANG +: BITRANG]
- sr_vld  out  NUMSRPT  per-port result valid
- sr_bmp  out  NUMSRPT*NUMADDR  per-port match bitmap; port p uses [p*NUMADDR +: NUMADDR]
- sr_hit  out  NUMSRPT  per-port: at least one bitmap bit set
- sr_adr  out  NUMSRPT*BITADDR  per-port lowest matching index

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - Clears every entry valid bit and every pipeline valid.
  - sr_vld, sr_bmp, sr_hit and sr_adr all read 0 in the cycle after rst is sampled high.
  - Min/max storage is not reset.
  - Searches in flight when rst asserts are dropped; no sr_vld pulse is produced for them.
  - Writes, clear and search are ignored while rst is high.
- Writes:
  - Take effect at the clk edge ending cycle T.
  - Write port 1 wins when both ports write the same address in the same cycle.
  - Writing with the valid bit at 0 invalidates that entry.
- clear:
  - Zeroes all valid bits at the edge ending cycle T.
  - A write in the same cycle is applied after the clear, so the written entry holds wr_din.
- Search pipeline, fixed latency 3, fully pipelined (one new search per port per cycle):
  - Stage 1, edge ending T: register search[p] and key[p].
  - Stage 2, during T+1: compare key[p] against all entries using storage as updated at the end of T; register the bitmap at the edge ending T+1.
  - Stage 3, during T+2: priority-encode the lowest set bit; register sr_hit and sr_adr, and carry the bitmap forward, at the edge ending T+2.
  - Results are visible in cycle T+3 with sr_vld[p]=1.
- Write/search ordering: a write or clear in cycle T is seen by a search issued in T. A write in T+1 or later is not seen by it.
- Bitmap rule: bit i = valid_i AND min_i<=key AND (RNGMODE ? key<max_i : key<=max_i). Compares are unsigned.
- Degenerate entries:
  - min>max never matches.
  - In RNGMODE 1, min==max never matches.
- Output hold when search not issued: when search[p] was 0 three cycles earlier, sr_vld[p]=0 and sr_bmp, sr_hit and sr_adr for port p hold their previous values.
- No match: sr_hit=0 and sr_adr=0.
- Overlapping ranges: all matching bits are set; sr_adr reports the lowest index.
- Port independence: ports are fully independent. Identical keys on two ports in the same cycle give identical results.
- Handshake: none (no backpressure); the consumer must accept every sr_vld pulse.

Test Plan:
- Reset, then search key 5 on port 0 -> sr_vld[0]=1 three cycles later, sr_bmp=0, sr_hit=0, sr_adr=0.
- Write entry 3={1,10,20} and entry 7={1,15,30}; search key 15 on port 0 and key 25 on port 1 in the same cycle -> port 0 bmp bits 3 and 7, sr_adr=3; port 1 bmp bit 7 only, sr_adr=7.
- RNGMODE=1, entry 2={1,10,20}: key 20 -> no hit; key 19 -> hit, sr_adr=2. RNGMODE=0: key 20 -> hit.
- Write entry 4={1,0,255} in cycle T with search key 9 also in T -> hit at sr_adr 4. Same write in T+1 instead -> search from T misses.
- Both ports write address 6 in the same cycle (port 0 {1,0,5}, port 1 {1,50,60}); search key 55 -> hit at 6. Search key 3 -> no hit.
- Entries 3 and 7 valid; clear plus a write of entry 9={1,0,100} in the same cycle; search key 15 -> bitmap has bit 9 only. Then assert rst with 2 searches in flight -> no sr_vld pulses and all outputs 0.
